wb_byte_ram_bridge: RTL

WB_BYTE_RAM_BRIDGE -- requirements
Module: wb_byte_ram_bridge

---
 rtl/wb_byte_ram_bridge.sv | 114 +++++++++++
 1 files changed

// File: rtl/wb_byte_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_byte_ram_bridge
// Purpose  : Bridges a 32-bit Wishbone-style slave port onto an 8-bit byte
//            RAM. Each request is split into four byte accesses. Writes honour
//            the byte selects. Reads always fetch all four bytes and assemble
//            them little-endian into o_wb_rdt.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            i_wb_adr/dat/sel  - word address, write data, byte enables
//            i_wb_we/stb       - direction, request strobe
//            o_wb_rdt/ack      - read data, one-cycle completion pulse
//            o_ram_*           - byte RAM write port and read address
//            i_ram_rdata       - byte RAM read data (one-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module wb_byte_ram_bridge #(
  parameter int aw = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [aw-3:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_ram_wen,
  output logic [aw-1:0] o_ram_waddr,
  output logic [7:0]    o_ram_wdata,
  output logic [aw-1:0] o_ram_raddr,
  input  logic [7:0]    i_ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [aw-3:0] r_adr;
  logic [31:0]   r_dat;
  logic [3:0]    r_sel;
  logic          r_we;

  logic [aw-1:0] w_addr;
  logic [1:0]    w_cap_idx;

  // Byte address is the latched word address with the byte counter appended,
  // so the top word never wraps into word 0.
  assign w_addr      = {r_adr, r_cnt};
  assign o_ram_raddr = w_addr;
  assign o_ram_waddr = w_addr;
  assign o_ram_wdata = r_dat[{r_cnt, 3'b000} +: 8];
  // Reset gates the enable directly so an aborted write stops in the very
  // cycle reset is raised, not one cycle later.
  assign o_ram_wen   = !reset && (r_state == XFER) && r_we && r_sel[r_cnt];

  // RAM read data lags the address by one cycle, so the byte arriving now
  // belongs to the previous counter value.
  assign w_cap_idx   = r_cnt - 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 2'd0;
      r_adr    <= '0;
      r_dat    <= 32'd0;
      r_sel    <= 4'd0;
      r_we     <= 1'b0;
      o_wb_rdt <= 32'd0;
      o_wb_ack <= 1'b0;
    end else begin
      o_wb_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_wb_stb) begin
            r_adr   <= i_wb_adr;
            r_dat   <= i_wb_dat;
            r_sel   <= i_wb_sel;
            r_we    <= i_wb_we;
            r_cnt   <= 2'd0;
            r_state <= XFER;
          end
        end
        XFER: begin
          r_cnt <= r_cnt + 2'd1;
          if (!r_we && (r_cnt != 2'd0))
            o_wb_rdt[{w_cap_idx, 3'b000} +: 8] <= i_ram_rdata;
          if (r_cnt == 2'd3)
            r_state <= DRAIN;
        end
        DRAIN: begin
          // Last read byte arrives here, one cycle after the final address.
          if (!r_we)
            o_wb_rdt[31:24] <= i_ram_rdata;
          o_wb_ack <= 1'b1;
          r_state  <= ACK;
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
